// File: rtl/ram_playback_ctl_pkg.sv
// Shared geometry constants and FSM encoding for the RAM playback controller
// and its length converter.
package ram_playback_ctl_pkg;

    localparam int unsigned RamDw             = 512;
    localparam int unsigned RamCyclesPerBlock = 64;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StLaunch,
        StWait,
        StGap
    } state_e;

    // log2 of bytes carried per stream cycle
    function automatic int unsigned bytes_shift(input int unsigned dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/ram_length_calc.sv
// Registered conversion of a byte count into whole RAM blocks plus the
// leftover cycles of a final partial block.
module ram_length_calc
    import ram_playback_ctl_pkg::*;
#(
    parameter int unsigned DW                   = RamDw,
    parameter int unsigned CYCLES_PER_RAM_BLOCK = RamCyclesPerBlock
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic [31:0] bytes_i,
    output logic [31:0] full_blocks_o,
    output logic [7:0]  partial_block_cycles_o
);

    localparam int unsigned BytesShift = bytes_shift(DW);
    localparam int unsigned BlockShift = $clog2(CYCLES_PER_RAM_BLOCK);
    localparam logic [32:0] BeatRound  = 33'((1 << BytesShift) - 1);
    localparam logic [31:0] BlockMask  = 32'(CYCLES_PER_RAM_BLOCK - 1);

    logic [32:0] bytes_rnd;
    logic [31:0] total_cycles;
    logic [31:0] full_d, full_q;
    logic [7:0]  partial_d, partial_q;

    // 33-bit sum so a byte count near 2^32 still rounds up correctly
    assign bytes_rnd    = {1'b0, bytes_i} + BeatRound;
    assign total_cycles = 32'(bytes_rnd >> BytesShift);
    assign full_d       = total_cycles >> BlockShift;
    assign partial_d    = 8'(total_cycles & BlockMask);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full_q    <= '0;
            partial_q <= '0;
        end else if (load_i) begin
            full_q    <= full_d;
            partial_q <= partial_d;
        end
    end

    assign full_blocks_o          = full_q;
    assign partial_block_cycles_o = partial_q;

endmodule

// File: rtl/ram_playback_ctl.sv
// Runs a ram_reader channel through a programmable number of playback passes
// with an idle gap between passes and a graceful stop.
module ram_playback_ctl
    import ram_playback_ctl_pkg::*;
#(
    parameter int unsigned DW                   = RamDw,
    parameter int unsigned CYCLES_PER_RAM_BLOCK = RamCyclesPerBlock
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] cfg_bytes_i,
    input  logic [15:0] cfg_repeat_i,
    input  logic [15:0] cfg_gap_i,
    input  logic        cmd_start_i,
    input  logic        cmd_stop_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        stopped_o,
    output logic        cfg_error_o,
    output logic [15:0] pass_count_o,
    output logic [31:0] rdr_full_blocks_o,
    output logic [7:0]  rdr_partial_block_cycles_o,
    output logic        rdr_start_o,
    input  logic        rdr_idle_i
);

    state_e      state_q, state_d;
    logic [31:0] bytes_q, bytes_d;
    logic [15:0] repeat_q, repeat_d;
    logic [15:0] gap_q, gap_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] pass_count_q, pass_count_d;
    logic [15:0] pass_next;
    logic        stop_pending_q, stop_pending_d;
    logic        stopped_q, stopped_d;
    logic        done_q, done_d;
    logic        cfg_error_q, cfg_error_d;
    logic        wait_first_q;
    logic        stop_now;
    logic        calc_load;

    assign pass_next = (pass_count_q == 16'hFFFF) ? pass_count_q : pass_count_q + 16'd1;
    assign stop_now  = stop_pending_q | cmd_stop_i;

    always_comb begin
        state_d        = state_q;
        bytes_d        = bytes_q;
        repeat_d       = repeat_q;
        gap_d          = gap_q;
        gap_cnt_d      = gap_cnt_q;
        pass_count_d   = pass_count_q;
        stop_pending_d = stop_pending_q;
        stopped_d      = stopped_q;
        done_d         = 1'b0;
        cfg_error_d    = 1'b0;
        calc_load      = 1'b0;

        if (state_q != StIdle && cmd_stop_i) begin
            stop_pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_start_i) begin
                    if (cfg_bytes_i == 32'd0) begin
                        cfg_error_d = 1'b1;
                    end else begin
                        bytes_d        = cfg_bytes_i;
                        repeat_d       = cfg_repeat_i;
                        gap_d          = cfg_gap_i;
                        pass_count_d   = 16'd0;
                        stopped_d      = 1'b0;
                        stop_pending_d = 1'b0;
                        state_d        = StPrep;
                    end
                end
            end
            StPrep: begin
                calc_load = 1'b1;
                state_d   = StLaunch;
            end
            StLaunch: begin
                state_d = StWait;
            end
            StWait: begin
                // the reader reports idle while start is still in flight
                if (!wait_first_q && rdr_idle_i) begin
                    pass_count_d = pass_next;
                    if (stop_now || (repeat_q != 16'd0 && pass_next == repeat_q)) begin
                        done_d         = 1'b1;
                        stopped_d      = stop_now;
                        stop_pending_d = 1'b0;
                        state_d        = StIdle;
                    end else if (gap_q == 16'd0) begin
                        state_d = StLaunch;
                    end else begin
                        gap_cnt_d = gap_q;
                        state_d   = StGap;
                    end
                end
            end
            StGap: begin
                if (stop_now) begin
                    done_d         = 1'b1;
                    stopped_d      = 1'b1;
                    stop_pending_d = 1'b0;
                    state_d        = StIdle;
                end else if (gap_cnt_q <= 16'd1) begin
                    state_d = StLaunch;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= StIdle;
            bytes_q        <= '0;
            repeat_q       <= '0;
            gap_q          <= '0;
            gap_cnt_q      <= '0;
            pass_count_q   <= '0;
            stop_pending_q <= 1'b0;
            stopped_q      <= 1'b0;
            done_q         <= 1'b0;
            cfg_error_q    <= 1'b0;
            wait_first_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            bytes_q        <= bytes_d;
            repeat_q       <= repeat_d;
            gap_q          <= gap_d;
            gap_cnt_q      <= gap_cnt_d;
            pass_count_q   <= pass_count_d;
            stop_pending_q <= stop_pending_d;
            stopped_q      <= stopped_d;
            done_q         <= done_d;
            cfg_error_q    <= cfg_error_d;
            wait_first_q   <= (state_q == StLaunch);
        end
    end

    ram_length_calc #(
        .DW                  (DW),
        .CYCLES_PER_RAM_BLOCK(CYCLES_PER_RAM_BLOCK)
    ) u_length_calc (
        .clk_i                 (clk_i),
        .reset_i               (reset_i),
        .load_i                (calc_load),
        .bytes_i               (bytes_q),
        .full_blocks_o         (rdr_full_blocks_o),
        .partial_block_cycles_o(rdr_partial_block_cycles_o)
    );

    assign busy_o       = (state_q != StIdle);
    assign rdr_start_o  = (state_q == StLaunch);
    assign done_o       = done_q;
    assign stopped_o    = stopped_q;
    assign cfg_error_o  = cfg_error_q;
    assign pass_count_o = pass_count_q;

endmodule

// File: tb/tb_ram_playback_ctl.sv
// Self-checking bench for ram_playback_ctl with a behavioural reader model
// and directed plus randomized playback runs.
module tb_ram_playback_ctl;

    localparam int unsigned BytesPerCycle  = 64;
    localparam int unsigned CyclesPerBlock = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cfg_bytes = '0;
    logic [15:0] cfg_repeat = '0;
    logic [15:0] cfg_gap = '0;
    logic        cmd_start = 1'b0;
    logic        cmd_stop = 1'b0;
    logic        busy, done, stopped, cfg_error, rdr_start;
    logic [15:0] pass_count;
    logic [31:0] rdr_full;
    logic [7:0]  rdr_partial;
    logic        rdr_idle = 1'b1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_starts = 0;
    int n_done = 0;
    int n_err = 0;
    int rd_lat = 10;
    int arm = 0;
    int rem = 0;
    int done_pass = 0;
    int done_stopped = 0;
    int start_cyc[$];
    int rise_cyc[$];

    ram_playback_ctl #(
        .DW                  (512),
        .CYCLES_PER_RAM_BLOCK(64)
    ) dut (
        .clk_i                     (clk),
        .reset_i                   (reset),
        .cfg_bytes_i               (cfg_bytes),
        .cfg_repeat_i              (cfg_repeat),
        .cfg_gap_i                 (cfg_gap),
        .cmd_start_i               (cmd_start),
        .cmd_stop_i                (cmd_stop),
        .busy_o                    (busy),
        .done_o                    (done),
        .stopped_o                 (stopped),
        .cfg_error_o               (cfg_error),
        .pass_count_o              (pass_count),
        .rdr_full_blocks_o         (rdr_full),
        .rdr_partial_block_cycles_o(rdr_partial),
        .rdr_start_o               (rdr_start),
        .rdr_idle_i                (rdr_idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    // Reader model and event monitor, updated mid-cycle. Idle stays high through
    // the first cycle after start to mimic the reader's idle term.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                rdr_idle = 1'b1;
                arm      = 0;
                rem      = 0;
            end else begin
                if (rdr_start) begin
                    n_starts++;
                    start_cyc.push_back(cyc);
                    arm = 2;
                end else if (arm != 0) begin
                    arm--;
                    if (arm == 0) begin
                        rdr_idle = 1'b0;
                        rem      = rd_lat;
                    end
                end else if (!rdr_idle) begin
                    rem--;
                    if (rem <= 0) begin
                        rdr_idle = 1'b1;
                        rise_cyc.push_back(cyc);
                    end
                end
                if (done) begin
                    n_done++;
                    done_pass    = int'(pass_count);
                    done_stopped = int'(stopped);
                end
                if (cfg_error) n_err++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void exp_len(input logic [31:0] b, output logic [31:0] f,
                                    output logic [7:0] p);
        longint unsigned tc;
        tc = ({32'd0, b} + 64'(BytesPerCycle - 1)) / 64'(BytesPerCycle);
        f  = 32'(tc / 64'(CyclesPerBlock));
        p  = 8'(tc % 64'(CyclesPerBlock));
    endfunction

    task automatic launch(input logic [31:0] bytes, input logic [15:0] rep,
                          input logic [15:0] gap, input int lat, output int req);
        @(negedge clk);
        rd_lat   = lat;
        n_starts = 0;
        n_done   = 0;
        n_err    = 0;
        start_cyc.delete();
        rise_cyc.delete();
        cfg_bytes  = bytes;
        cfg_repeat = rep;
        cfg_gap    = gap;
        cmd_start  = 1'b1;
        req        = cyc;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        cmd_stop = 1'b1;
        @(negedge clk);
        cmd_stop = 1'b0;
    endtask

    task automatic wait_starts(input string tag, input int n);
        int t = 0;
        while (n_starts < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (n_starts < n) check({tag, "_start_timeout"}, 64'(n_starts), 64'(n));
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (n_done == 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done_seen"}, 64'(n_done != 0), 64'd1);
        @(negedge clk);
        check({tag, "_busy_after_done"}, 64'(busy), 64'd0);
        repeat (8) @(negedge clk);
    endtask

    task automatic play(input string tag, input logic [31:0] bytes, input logic [15:0] rep,
                        input logic [15:0] gap, input int lat);
        logic [31:0] ef;
        logic [7:0]  ep;
        int          req;
        int          lat_obs;
        exp_len(bytes, ef, ep);
        launch(bytes, rep, gap, lat, req);
        wait_done(tag);
        lat_obs = (start_cyc.size() != 0) ? start_cyc[0] - req : -1;
        check({tag, "_start_latency"}, 64'(lat_obs), 64'd2);
        check({tag, "_full"}, 64'(rdr_full), 64'(ef));
        check({tag, "_partial"}, 64'(rdr_partial), 64'(ep));
        check({tag, "_starts"}, 64'(n_starts), 64'(rep));
        check({tag, "_done_count"}, 64'(n_done), 64'd1);
        check({tag, "_pass_count"}, 64'(done_pass), 64'(rep));
        check({tag, "_stopped"}, 64'(done_stopped), 64'd0);
        for (int i = 1; i < start_cyc.size(); i++) begin
            if (i - 1 < rise_cyc.size())
                check({tag, "_gap"}, 64'(start_cyc[i] - rise_cyc[i-1]), 64'(gap) + 64'd1);
        end
    endtask

    initial begin
        int          req;
        logic [31:0] rb;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stopped", 64'(stopped), 64'd0);
        check("rst_cfg_error", 64'(cfg_error), 64'd0);
        check("rst_rdr_start", 64'(rdr_start), 64'd0);
        check("rst_pass_count", 64'(pass_count), 64'd0);
        check("rst_full", 64'(rdr_full), 64'd0);
        check("rst_partial", 64'(rdr_partial), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        play("single_8192", 32'd8192, 16'd1, 16'd0, 128);
        play("len_4100", 32'd4100, 16'd1, 16'd0, 4);
        play("len_100", 32'd100, 16'd1, 16'd0, 4);
        play("len_64", 32'd64, 16'd1, 16'd0, 4);
        play("len_max", 32'hFFFF_FFFF, 16'd1, 16'd0, 3);
        play("rep3_gap5", 32'd4096, 16'd3, 16'd5, 10);

        for (int i = 0; i < 6; i++) begin
            rb = (i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 20000));
            if (rb == 32'd0) rb = 32'd1;
            play("random", rb, 16'($urandom_range(1, 3)), 16'($urandom_range(0, 4)),
                 int'($urandom_range(2, 12)));
        end

        // continuous mode, stop during the second pass
        launch(32'd640, 16'd0, 16'd2, 20, req);
        wait_starts("stop_wait", 2);
        repeat (3) @(negedge clk);
        pulse_stop();
        wait_done("stop_wait");
        check("stop_wait_starts", 64'(n_starts), 64'd2);
        check("stop_wait_pass", 64'(done_pass), 64'd2);
        check("stop_wait_stopped", 64'(done_stopped), 64'd1);
        check("stop_wait_stopped_held", 64'(stopped), 64'd1);

        // continuous mode, stop during the gap after the second pass
        launch(32'd640, 16'd0, 16'd10, 4, req);
        begin
            int t = 0;
            while (rise_cyc.size() < 2 && t < 2000) begin
                @(negedge clk);
                t++;
            end
        end
        repeat (2) @(negedge clk);
        pulse_stop();
        wait_done("stop_gap");
        check("stop_gap_starts", 64'(n_starts), 64'd2);
        check("stop_gap_pass", 64'(done_pass), 64'd2);
        check("stop_gap_stopped", 64'(done_stopped), 64'd1);

        // zero-length start is rejected
        launch(32'd0, 16'd1, 16'd0, 4, req);
        check("zero_busy", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        check("zero_cfg_error", 64'(n_err), 64'd1);
        check("zero_starts", 64'(n_starts), 64'd0);
        check("zero_busy_late", 64'(busy), 64'd0);
        check("zero_stopped_kept", 64'(stopped), 64'd1);

        // start while busy is ignored
        launch(32'd4100, 16'd2, 16'd3, 10, req);
        wait_starts("busy_start", 1);
        repeat (2) @(negedge clk);
        cfg_bytes  = 32'd64;
        cfg_repeat = 16'd1;
        cmd_start  = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        wait_done("busy_start");
        check("busy_start_pass", 64'(done_pass), 64'd2);
        check("busy_start_starts", 64'(n_starts), 64'd2);
        check("busy_start_full", 64'(rdr_full), 64'd1);
        check("busy_start_partial", 64'(rdr_partial), 64'd1);
        check("busy_start_err", 64'(n_err), 64'd0);

        // reset during the second pass
        launch(32'd8192, 16'd0, 16'd0, 30, req);
        wait_starts("mid_reset", 2);
        repeat (4) @(negedge clk);
        check("mid_reset_pass_before", 64'(pass_count), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_busy", 64'(busy), 64'd0);
        check("mid_reset_rdr_start", 64'(rdr_start), 64'd0);
        check("mid_reset_pass", 64'(pass_count), 64'd0);
        check("mid_reset_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        check("mid_reset_no_done", 64'(n_done), 64'd0);
        play("after_reset", 32'd100, 16'd2, 16'd1, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
